// File: rtl/fifo_push_arbiter_if.sv
// Write-side bundle between NB_REQ producers, the push arbiter and one sync_fifo.
// The producer/FIFO side uses the master modport; the arbiter uses slave.
interface fifo_push_arbiter_if #(
  parameter int NB_REQ     = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_W = $clog2(NB_REQ);

  logic [NB_REQ-1:0]            req_valid;
  logic [NB_REQ-1:0]            req_last;
  logic [NB_REQ*DATA_WIDTH-1:0] req_data;
  logic [NB_REQ-1:0]            req_ready;
  logic                         fifo_push;
  logic [DATA_WIDTH-1:0]        fifo_data;
  logic                         fifo_full;
  logic                         grant_valid;
  logic [ID_W-1:0]              grant_id;

  modport master (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_push, fifo_data, grant_valid, grant_id
  );

  modport slave (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_push, fifo_data, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter sharing one sync_fifo write port among NB_REQ producers.
// Optional macro FIFO_ARB_BURST_LIMIT_EN caps a grant at MAX_BURST beats.
module fifo_push_arbiter #(
  parameter int NB_REQ     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                aclk,
  input  logic                srst,
  fifo_push_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(NB_REQ);

  if (NB_REQ < 2 || NB_REQ > 16 || MAX_BURST < 2 || MAX_BURST > 256) begin : g_bad_param
    $error("fifo_push_arbiter: parameter out of range");
  end

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t            state_r;
  logic [ID_W-1:0]   grant_id_r;
  logic [ID_W-1:0]   rr_ptr_r;
  logic [ID_W:0]     pick_s;
  logic [ID_W-1:0]   next_ptr_s;
  logic [NB_REQ-1:0] ready_s;
  logic              push_s;
  logic              last_s;
  logic              burst_end_s;

  // Returns {found, index}; scanning downward leaves the smallest circular distance from ptr.
  function automatic logic [ID_W:0] pick_next(input logic [NB_REQ-1:0] valid,
                                              input logic [ID_W-1:0]   ptr);
    logic [ID_W:0] res;
    int            idx;
    res = {1'b0, {ID_W{1'b0}}};
    for (int k = NB_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NB_REQ) begin
        idx = idx - NB_REQ;
      end else begin
        idx = idx;
      end
      if (valid[idx]) begin
        res = {1'b1, ID_W'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign pick_s     = pick_next(bus.req_valid, rr_ptr_r);
  assign next_ptr_s = (grant_id_r == ID_W'(NB_REQ - 1)) ? {ID_W{1'b0}} : grant_id_r + ID_W'(1);
  assign last_s     = bus.req_last[grant_id_r];

  // Only the granted requester sees ready, and only while the FIFO has room.
  always_comb begin
    ready_s = {NB_REQ{1'b0}};
    if (state_r == ST_GRANT) begin
      ready_s[grant_id_r] = ~bus.fifo_full;
    end else begin
      ready_s = {NB_REQ{1'b0}};
    end
  end

  assign push_s = (state_r == ST_GRANT) & bus.req_valid[grant_id_r] & ~bus.fifo_full;

`ifdef FIFO_ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  logic [CNT_W-1:0] burst_cnt_r;
  assign burst_end_s = push_s & (last_s | (burst_cnt_r == CNT_W'(MAX_BURST - 1)));
`else
  assign burst_end_s = push_s & last_s;
`endif

  // Arbitration FSM: latch a winner in IDLE, hold it until its burst ends, then rotate.
  always_ff @(posedge aclk) begin
    if (srst) begin
      state_r    <= ST_IDLE;
      grant_id_r <= {ID_W{1'b0}};
      rr_ptr_r   <= {ID_W{1'b0}};
`ifdef FIFO_ARB_BURST_LIMIT_EN
      burst_cnt_r <= {CNT_W{1'b0}};
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_s[ID_W]) begin
            grant_id_r <= pick_s[ID_W-1:0];
            state_r    <= ST_GRANT;
`ifdef FIFO_ARB_BURST_LIMIT_EN
            burst_cnt_r <= {CNT_W{1'b0}};
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (push_s) begin
`ifdef FIFO_ARB_BURST_LIMIT_EN
            burst_cnt_r <= burst_cnt_r + CNT_W'(1);
`endif
            if (burst_end_s) begin
              rr_ptr_r <= next_ptr_s;
              state_r  <= ST_IDLE;
            end else begin
              state_r <= ST_GRANT;
            end
          end else begin
            state_r <= ST_GRANT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = ready_s;
  assign bus.fifo_push   = push_s;
  assign bus.fifo_data   = bus.req_data[int'(grant_id_r)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.grant_valid = (state_r == ST_GRANT);
  assign bus.grant_id    = grant_id_r;
endmodule
